adder_error_monitor: RTL and testbench
======================================

# adder_error_monitor

Streaming error-characterisation stage that sits directly downstream of the HOERAA approximate adder. Each cycle it accepts one operand pair plus the adder's approximate result {co, s}, recomputes the exact sum, and accumulates error metrics over a fixed window of samples: sample count, error count, sum of error distances and maximum error distance. It replaces hand-checking of `$monitor` output in adder benches and gives the synthesis flow a measurable accuracy figure for each K setting.

## Interface
Parameters:
- N, 16, operand width; matches the adder's N.
- K, 6, approximate-part width of the adder under test; used only for the low-part error counter.
- WINDOW, 1024, samples per measurement window; legal range 1..2^ACC_W-1.
- ACC_W, 32, width of every accumulator and counter.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; clears all metrics and opens a new window.
- in_valid  in  1  sample strobe.
- in_ready  out  1  high only in RUN.
- x, y  in  N  adder operands.
- s  in  N  approximate sum from the adder.
- co  in  1  approximate carry-out from the adder.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; metrics are frozen and valid.
- sample_cnt  out  ACC_W  number of accepted samples.
- err_cnt  out  ACC_W  samples with approx != exact.
- lo_err_cnt  out  ACC_W  samples where only bits [K-1:0] differ.
- sed  out  ACC_W  sum of |exact - approx|.
- max_ed  out  N+1  largest single error distance.

## Operation
- Exact sum: x + y, N+1 bits, zero-extended operands. Approx: {co, s}, N+1 bits, unsigned.
- ED = |exact - approx|, N+1 bits, always non-negative.
- A sample is accepted when in_valid && in_ready.
- FSM: IDLE -> (start) RUN -> (WINDOW-th sample accepted) DRAIN -> (pipeline empty) DONE -> (start) RUN.
- start in any state clears all metrics and goes to RUN. A sample presented in the same cycle as start is discarded, and any in-flight pipeline samples are flushed.
- Accumulators sed, sample_cnt, err_cnt and lo_err_cnt saturate at 2^ACC_W-1 and never wrap.
- max_ed updates when the new ED is strictly greater than the stored value.
- lo_err_cnt increments when approx != exact and (approx ^ exact) >> K == 0.
- Reset: state IDLE; all outputs 0; in_ready, busy and done low.

## Timing
- Two-stage pipeline. Stage 1 registers the exact sum, the approx sum and the valid bit. Stage 2 registers the ED and the compare flags and updates the accumulators.
- Metrics reflect an accepted sample 2 cycles after acceptance.
- in_ready drops in the cycle after the WINDOW-th acceptance.
- DRAIN lasts exactly 2 cycles; done rises on the 3rd cycle after the last acceptance.
- No back-pressure inside the block. in_valid while in_ready is low is ignored.
- The block adds no combinational path from inputs to outputs.

## Configuration
- SQ_ERR_EN, when defined, adds an output port `ssed` (2*(N+1) bits, saturating) that accumulates ED*ED for mean-squared-error computation.
- The squaring is registered, which adds one pipeline stage: metric latency becomes 3 and DRAIN becomes 3 cycles.
- When undefined, the port, multiplier and extra stage are absent, and latency is 2.

## Structure
- Package `adder_eval_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the saturating-add function;
  - the localparam for the DRAIN depth, selected by SQ_ERR_EN.
- Sub-module `abs_diff` (parameter W) computes the registered |a - b| for W-bit unsigned operands. It is instantiated once with W = N+1.

## Test plan
- Reset then start; x=1, y=1, s=2, co=0 -> after done: sample_cnt=1, err_cnt=0, sed=0, max_ed=0 (WINDOW=1).
- x=16'h00FF, y=16'h00FF, s=16'h01FC, co=0 (exact 0x1FE) -> err_cnt=1, lo_err_cnt=1, sed=2, max_ed=2.
- x=y=16'hFFFF, s=16'hFFFE, co=0 (exact 0x1FFFE) -> ED=0x10000, lo_err_cnt=0, max_ed=0x10000.
- WINDOW=4 with a sample on every cycle -> in_ready low from cycle 5, done on cycle 7 after the first acceptance, sample_cnt=4, and a 5th in_valid is ignored.
- start pulsed mid-window alongside a valid sample -> all metrics read 0 next cycle, that sample is not counted, and FSM is in RUN.
- ACC_W=4 with 20 erroneous samples of ED=1 -> err_cnt and sed saturate at 15 with no wrap.

Source files
------------

// File: rtl/adder_eval_pkg.sv
`default_nettype none
// adder_eval_pkg: shared state encoding, drain depth and saturating add for the adder error monitor.
// Optional macro SQ_ERR_EN deepens the pipeline by one stage. Rev 1.0
package adder_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

`ifdef SQ_ERR_EN
  localparam int DRAIN_DEPTH = 3;
`else
  localparam int DRAIN_DEPTH = 2;
`endif

  // Callers zero-extend operands to 64 bits and cast the result back to their width.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] lim);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    return sum[63:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/abs_diff.sv
`default_nettype none
// abs_diff: registered absolute difference of two W-bit unsigned operands.
// Rev 1.0
module abs_diff #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] d
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      d <= '0;
    end else begin
      d <= (a >= b) ? (a - b) : (b - a);
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_error_monitor.sv
`default_nettype none
// adder_error_monitor: windowed error metrics (count, error count, SED, max ED) for an approximate adder.
// Optional macro SQ_ERR_EN adds the saturating ssed output (sum of squared ED). Rev 1.0
module adder_error_monitor
  import adder_eval_pkg::*;
#(
  parameter int N      = 16,
  parameter int K      = 6,
  parameter int WINDOW = 1024,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  input  logic [N-1:0]     s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sample_cnt,
  output logic [ACC_W-1:0] err_cnt,
  output logic [ACC_W-1:0] lo_err_cnt,
  output logic [ACC_W-1:0] sed,
`ifdef SQ_ERR_EN
  output logic [2*(N+1)-1:0] ssed,
`endif
  output logic [N:0]       max_ed
);

  localparam int EW = N + 1;
  localparam logic [63:0] ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  state_t           state;
  state_t           state_nx;
  logic [ACC_W-1:0] win_cnt;
  logic [1:0]       drain_cnt;
  logic             accept;
  logic             last_accept;

  assign accept      = in_valid && (state == RUN) && !start;
  assign last_accept = accept && (win_cnt == ACC_W'(WINDOW - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      RUN:     if (last_accept) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'(DRAIN_DEPTH - 1)) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      win_cnt <= '0;
    end else if (accept) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // Stage 1: exact and approximate sums.
  logic [EW-1:0] exact1;
  logic [EW-1:0] approx1;
  logic          v1;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      exact1  <= '0;
      approx1 <= '0;
      v1      <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        exact1  <= {1'b0, x} + {1'b0, y};
        approx1 <= {co, s};
      end
    end
  end

  // Stage 2: error distance and compare flags.
  logic [EW-1:0] diff1;
  logic [EW-1:0] ed2;
  logic          v2;
  logic          err2;
  logic          lo2;

  assign diff1 = exact1 ^ approx1;

  abs_diff #(.W(EW)) u_abs_diff (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .a   (exact1),
    .b   (approx1),
    .d   (ed2)
  );

  always_ff @(posedge clk) begin
    if (rst || start) begin
      v2   <= 1'b0;
      err2 <= 1'b0;
      lo2  <= 1'b0;
    end else begin
      v2   <= v1;
      err2 <= v1 && (diff1 != '0);
      lo2  <= v1 && (diff1 != '0) && ((diff1 >> K) == '0);
    end
  end

  logic          acc_v;
  logic          acc_err;
  logic          acc_lo;
  logic [EW-1:0] acc_ed;

`ifdef SQ_ERR_EN
  localparam logic [63:0] SQ_MAX = (64'd1 << (2 * EW)) - 64'd1;

  logic [2*EW-1:0] sq3;
  logic [EW-1:0]   ed3;
  logic            v3;
  logic            err3;
  logic            lo3;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      sq3  <= '0;
      ed3  <= '0;
      v3   <= 1'b0;
      err3 <= 1'b0;
      lo3  <= 1'b0;
    end else begin
      sq3  <= (2*EW)'(ed2) * (2*EW)'(ed2);
      ed3  <= ed2;
      v3   <= v2;
      err3 <= err2;
      lo3  <= lo2;
    end
  end

  assign acc_v   = v3;
  assign acc_err = err3;
  assign acc_lo  = lo3;
  assign acc_ed  = ed3;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      ssed <= '0;
    end else if (acc_v) begin
      ssed <= (2*EW)'(sat_add(64'(ssed), 64'(sq3), SQ_MAX));
    end
  end
`else
  assign acc_v   = v2;
  assign acc_err = err2;
  assign acc_lo  = lo2;
  assign acc_ed  = ed2;
`endif

  // Final stage: saturating accumulators; max_ed takes strictly larger distances only.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      lo_err_cnt <= '0;
      sed        <= '0;
      max_ed     <= '0;
    end else if (acc_v) begin
      sample_cnt <= ACC_W'(sat_add(64'(sample_cnt), 64'd1, ACC_MAX));
      sed        <= ACC_W'(sat_add(64'(sed), 64'(acc_ed), ACC_MAX));
      if (acc_err) err_cnt    <= ACC_W'(sat_add(64'(err_cnt), 64'd1, ACC_MAX));
      if (acc_lo)  lo_err_cnt <= ACC_W'(sat_add(64'(lo_err_cnt), 64'd1, ACC_MAX));
      if (acc_ed > max_ed) max_ed <= acc_ed;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_error_monitor.sv
`default_nettype none
// tb_adder_error_monitor: directed self-checking bench for adder_error_monitor.
// Rev 1.0
module tb_adder_error_monitor;
  import adder_eval_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] x = '0, y = '0, s = '0;
  logic        co = 1'b0;
  logic        start_a = 0, start_b = 0, start_c = 0;
  logic        valid_a = 0, valid_b = 0, valid_c = 0;

  logic        rdy_a, busy_a, done_a, rdy_b, busy_b, done_b, rdy_c, busy_c, done_c;
  logic [31:0] sc_a, ec_a, lc_a, sed_a, sc_b, ec_b, lc_b, sed_b;
  logic [3:0]  sc_c, ec_c, lc_c, sed_c;
  logic [16:0] mx_a, mx_b, mx_c;
`ifdef SQ_ERR_EN
  logic [33:0] ss_a, ss_b, ss_c;
`endif

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clk = ~clk;

  adder_error_monitor #(.N(16), .K(6), .WINDOW(1), .ACC_W(32)) ua (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_ready(rdy_a),
    .x(x), .y(y), .s(s), .co(co), .busy(busy_a), .done(done_a),
    .sample_cnt(sc_a), .err_cnt(ec_a), .lo_err_cnt(lc_a), .sed(sed_a),
`ifdef SQ_ERR_EN
    .ssed(ss_a),
`endif
    .max_ed(mx_a));

  adder_error_monitor #(.N(16), .K(6), .WINDOW(4), .ACC_W(32)) ub (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(rdy_b),
    .x(x), .y(y), .s(s), .co(co), .busy(busy_b), .done(done_b),
    .sample_cnt(sc_b), .err_cnt(ec_b), .lo_err_cnt(lc_b), .sed(sed_b),
`ifdef SQ_ERR_EN
    .ssed(ss_b),
`endif
    .max_ed(mx_b));

  adder_error_monitor #(.N(16), .K(6), .WINDOW(15), .ACC_W(4)) uc (
    .clk(clk), .rst(rst), .start(start_c), .in_valid(valid_c), .in_ready(rdy_c),
    .x(x), .y(y), .s(s), .co(co), .busy(busy_c), .done(done_c),
    .sample_cnt(sc_c), .err_cnt(ec_c), .lo_err_cnt(lc_c), .sed(sed_c),
`ifdef SQ_ERR_EN
    .ssed(ss_c),
`endif
    .max_ed(mx_c));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] xv, input logic [15:0] yv,
                       input logic [15:0] sv, input logic cv);
    x = xv; y = yv; s = sv; co = cv;
  endtask

  // Runs one single-sample window on ua: start, one accepted sample, then drain to done.
  task automatic one_shot(input logic [15:0] xv, input logic [15:0] yv,
                          input logic [15:0] sv, input logic cv, input string tag);
    start_a = 1; tick(); start_a = 0;
    chk({tag, "_ready"}, rdy_a, 1);
    drive(xv, yv, sv, cv); valid_a = 1; tick(); valid_a = 0;
    chk({tag, "_ready_drop"}, rdy_a, 0);
    for (int k = 1; k < DRAIN_DEPTH; k++) begin
      chk({tag, "_done_early"}, done_a, 0);
      tick();
    end
    tick();
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_busy"}, busy_a, 0);
  endtask

  initial begin
    tick(3);
    chk("rst_ready", rdy_a, 0);
    chk("rst_busy", busy_b, 0);
    chk("rst_done", done_c, 0);
    chk("rst_sample_cnt", sc_a, 0);
    chk("rst_sed", sed_b, 0);
    chk("rst_max_ed", mx_c, 0);
    rst = 0; tick();
    chk("idle_ready", rdy_a, 0);

    // Exact sample: no error.
    one_shot(16'd1, 16'd1, 16'd2, 1'b0, "A");
    chk("A_sample_cnt", sc_a, 1);
    chk("A_err_cnt", ec_a, 0);
    chk("A_sed", sed_a, 0);
    chk("A_max_ed", mx_a, 0);

    // Exact 0x1FE vs approx 0x1FC: low-part error of 2.
    one_shot(16'h00FF, 16'h00FF, 16'h01FC, 1'b0, "B");
    chk("B_sample_cnt", sc_a, 1);
    chk("B_err_cnt", ec_a, 1);
    chk("B_lo_err_cnt", lc_a, 1);
    chk("B_sed", sed_a, 2);
    chk("B_max_ed", mx_a, 2);

    // Exact 0x1FFFE vs approx 0x0FFFE: carry-out error, ED 0x10000.
    one_shot(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, "C");
    chk("C_err_cnt", ec_a, 1);
    chk("C_lo_err_cnt", lc_a, 0);
    chk("C_sed", sed_a, 32'h10000);
    chk("C_max_ed", mx_a, 17'h10000);

    // WINDOW=4, a sample offered every cycle; cycle 1 holds the first acceptance.
    start_b = 1; tick(); start_b = 0;
    valid_b = 1;
    for (int i = 1; i <= 7; i++) begin
      case (i)
        1: drive(16'd10, 16'd5, 16'd15, 1'b0);       // ED 0
        2: drive(16'd0, 16'd0, 16'd1, 1'b0);         // ED 1, low-part
        3: drive(16'h0100, 16'h0100, 16'h01C0, 1'b0); // ED 0x40, high bits differ
        4: drive(16'd0, 16'd0, 16'd5, 1'b0);         // ED 5, low-part
        default: drive(16'd0, 16'd0, 16'hFFFF, 1'b1); // must be ignored
      endcase
      tick();
      chk($sformatf("D_ready_c%0d", i + 1), rdy_b, (i + 1) <= 4);
      chk($sformatf("D_done_c%0d", i + 1), done_b, (i + 1) >= (4 + DRAIN_DEPTH + 1));
    end
    valid_b = 0;
    chk("D_sample_cnt", sc_b, 4);
    chk("D_err_cnt", ec_b, 3);
    chk("D_lo_err_cnt", lc_b, 2);
    chk("D_sed", sed_b, 70);
    chk("D_max_ed", mx_b, 17'h40);

    // Restart mid-window with samples in flight and a sample alongside start.
    start_b = 1; tick(); start_b = 0;
    drive(16'd0, 16'd0, 16'd1, 1'b0);
    valid_b = 1; tick(3);
    chk("E_pre_sample_cnt", sc_b != 0, 1);
    start_b = 1; drive(16'd0, 16'd0, 16'd5, 1'b0); tick();
    start_b = 0; valid_b = 0;
    chk("E_sample_cnt", sc_b, 0);
    chk("E_err_cnt", ec_b, 0);
    chk("E_sed", sed_b, 0);
    chk("E_max_ed", mx_b, 0);
    chk("E_ready", rdy_b, 1);
    chk("E_busy", busy_b, 1);
    tick(4);
    chk("E_flushed_cnt", sc_b, 0);
    chk("E_flushed_sed", sed_b, 0);
    drive(16'd0, 16'd0, 16'd2, 1'b0);
    valid_b = 1; tick(4); valid_b = 0;
    tick(DRAIN_DEPTH);
    chk("E_done", done_b, 1);
    chk("E_full_cnt", sc_b, 4);
    chk("E_full_sed", sed_b, 8);

    // ACC_W=4, WINDOW=15: 20 samples of ED 3 offered; sed would wrap to 13 without saturation.
    start_c = 1; tick(); start_c = 0;
    drive(16'd0, 16'd0, 16'd3, 1'b0);
    valid_c = 1; tick(20); valid_c = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done_c) seen = 1'b1;
      else tick();
    end
    chk("F_done_seen", seen, 1);
    chk("F_ready", rdy_c, 0);
    chk("F_sample_cnt", sc_c, 15);
    chk("F_err_cnt", ec_c, 15);
    chk("F_lo_err_cnt", lc_c, 15);
    chk("F_sed", sed_c, 15);
    chk("F_max_ed", mx_c, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
